// File: rtl/jtag_sync_pkg.sv
// rtl/jtag_sync_pkg.sv - shared types for the JTAG/fabric control and status synchronisers
package jtag_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCEPT = 2'd2
    } sync_state_t;

endpackage

// File: rtl/bit_sync2.sv
// rtl/bit_sync2.sv - parametric-width two-flop synchroniser with asynchronous active-low reset
module bit_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // cdc_s1 is the capture stage; the false-path/max-delay constraint targets this name.
    logic [WIDTH-1:0] cdc_s1;
    logic [WIDTH-1:0] cdc_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdc_s1 <= '0;
            cdc_s2 <= '0;
        end else begin
            cdc_s1 <= d;
            cdc_s2 <= cdc_s1;
        end
    end

    assign q = cdc_s2;

endmodule

// File: rtl/jtag_control_sync.sv
// rtl/jtag_control_sync.sv - coherent capture of the JTAG control word into the clk domain
module jtag_control_sync
    import jtag_sync_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       ctrl_async,
    output logic [WIDTH-1:0]       ctrl_q,
    output logic                   ctrl_valid,
    input  logic [WIDTH-1:0]       status_in,
    output logic [WIDTH-1:0]       status_out,
    output logic [COUNT_WIDTH-1:0] update_count
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] ctrl_s2;
    sync_state_t      state, state_nxt;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    bit_sync2 #(
        .WIDTH (WIDTH)
    ) u_ctrl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ctrl_async),
        .q     (ctrl_s2)
    );

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ctrl_s2 != ctrl_q) begin
                    state_nxt = SETTLE;
                    cand_nxt  = ctrl_s2;
                    cnt_nxt   = CNT_ONE;
                end
            end
            SETTLE: begin
                // Any change restarts the window, including a return to ctrl_q.
                if (ctrl_s2 != cand) begin
                    cand_nxt = ctrl_s2;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = ACCEPT;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ACCEPT: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            ctrl_q       <= RESET_VALUE;
            ctrl_valid   <= 1'b0;
            update_count <= '0;
            status_out   <= '0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            status_out <= status_in;
            ctrl_valid <= (state == ACCEPT);
            if (state == ACCEPT) begin
                ctrl_q       <= cand;
                update_count <= update_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtag_control_sync.sv
// tb/tb_jtag_control_sync.sv - randomized self-checking bench for jtag_control_sync
module tb_jtag_control_sync;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ctrl_async;
    logic [7:0] status_in;
    logic [7:0] ctrl_q, status_out, update_count;
    logic       ctrl_valid;
    logic [7:0] ctrl_q_w, status_out_w;
    logic       ctrl_valid_w;
    logic [1:0] update_count_w;

    always #10 clk = ~clk;

    jtag_control_sync dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_async   (ctrl_async),
        .ctrl_q       (ctrl_q),
        .ctrl_valid   (ctrl_valid),
        .status_in    (status_in),
        .status_out   (status_out),
        .update_count (update_count)
    );

    jtag_control_sync #(
        .COUNT_WIDTH (2)
    ) dut_w (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_async   (ctrl_async),
        .ctrl_q       (ctrl_q_w),
        .ctrl_valid   (ctrl_valid_w),
        .status_in    (status_in),
        .status_out   (status_out_w),
        .update_count (update_count_w)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    bit saw_5a  = 0;
    bit stat_fixed = 0;

    // Reference model: synced sample stream plus a run-length acceptance rule.
    logic [7:0] m_s1 = '0, m_s2 = '0, m_q = '0, m_val = '0, m_stat = '0;
    int         m_len = 0;
    int         m_cnt = 0;
    bit         m_due = 0;
    bit         m_valid = 0;

    task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task model_step();
        logic [7:0] y;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_q = '0; m_val = '0; m_stat = '0;
            m_len = 0; m_cnt = 0; m_due = 0; m_valid = 0;
            return;
        end
        y      = m_s2;
        m_s2   = m_s1;
        m_s1   = ctrl_async;
        m_stat = status_in;
        m_valid = 0;
        if (m_due) begin
            m_q = m_val; m_valid = 1; m_cnt++; m_due = 0;
        end else if (m_len != 0 && y == m_val) begin
            m_len++;
            if (m_len == STABLE) begin
                m_due = 1; m_len = 0;
            end
        end else if (m_len != 0 || y != m_q) begin
            m_val = y; m_len = 1;
        end
    endtask

    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("ctrl_q", 32'(ctrl_q), 32'(m_q));
        check_eq("ctrl_valid", 32'(ctrl_valid), 32'(m_valid));
        check_eq("update_count", 32'(update_count), 32'(m_cnt[7:0]));
        check_eq("update_count_w", 32'(update_count_w), 32'(m_cnt[1:0]));
        check_eq("status_out", 32'(status_out), 32'(m_stat));
        if (ctrl_valid) pulses++;
        if (ctrl_q == 8'h5A) saw_5a = 1;
    endtask

    task hold(input logic [7:0] v, input int n);
        ctrl_async = v;
        for (int i = 0; i < n; i++) begin
            status_in = stat_fixed ? 8'hA5 : 8'($urandom);
            tick();
        end
    endtask

    task do_reset();
        rst_n = 1'b0;
        hold(ctrl_async, 2);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        bit seen;
        int wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};

        rst_n = 1'b0; ctrl_async = '0; status_in = '0;

        for (int i = 0; i < 6; i++) hold(8'($urandom), 1);
        check_eq("rst_ctrl_q", 32'(ctrl_q), 32'h00);
        check_eq("rst_valid", 32'(ctrl_valid), 32'h0);
        check_eq("rst_count", 32'(update_count), 32'h0);
        check_eq("rst_status", 32'(status_out), 32'h0);
        ctrl_async = 8'h00;
        rst_n = 1'b1;
        hold(8'h00, 4);

        pulses = 0; lat = 0; seen = 0;
        ctrl_async = 8'h5A;
        while (lat < 20 && !seen) begin
            hold(8'h5A, 1);
            lat++;
            if (ctrl_valid) seen = 1;
        end
        check_eq("single_latency", 32'(lat), 32'd7);
        hold(8'h5A, 10);
        check_eq("single_pulses", 32'(pulses), 32'd1);
        check_eq("single_ctrl_q", 32'(ctrl_q), 32'h5A);
        check_eq("single_count", 32'(update_count), 32'd1);

        do_reset();
        hold(8'h00, 4);
        saw_5a = 0;
        hold(8'h5A, 3);
        hold(8'h00, 12);
        check_eq("glitch_never_5a", 32'(saw_5a), 32'd0);
        check_eq("glitch_ctrl_q", 32'(ctrl_q), 32'h00);
        check_eq("glitch_rewrite_count", 32'(update_count), 32'd1);

        pulses = 0;
        hold(8'h01, 2);
        hold(8'h02, 2);
        hold(8'h03, 14);
        check_eq("rapid_pulses", 32'(pulses), 32'd1);
        check_eq("rapid_ctrl_q", 32'(ctrl_q), 32'h03);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            hold(8'h11 + 8'(i), 10);
            check_eq("wrap_count", 32'(update_count_w), 32'(wrap_exp[i]));
        end

        stat_fixed = 1;
        do_reset();
        hold(8'h00, 4);
        hold(8'hC3, 2);
        rst_n = 1'b0;
        hold(8'hC3, 3);
        check_eq("midrst_ctrl_q", 32'(ctrl_q), 32'h00);
        rst_n = 1'b1;
        pulses = 0;
        hold(8'hC3, 12);
        check_eq("midrst_pulses", 32'(pulses), 32'd1);
        check_eq("midrst_ctrl_q_after", 32'(ctrl_q), 32'hC3);
        check_eq("midrst_status", 32'(status_out), 32'hA5);
        stat_fixed = 0;

        do_reset();
        for (int s = 0; s < 60; s++) begin
            logic [7:0] v;
            case ($urandom_range(0, 2))
                0:       v = 8'h00;
                1:       v = ctrl_q;
                default: v = 8'($urandom);
            endcase
            hold(v, int'($urandom_range(1, 8)));
        end
        hold(ctrl_async, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
